// File: rtl/avl_mm_pkg.sv
// Shared definitions for the Avalon-MM host multiplexer: response codes and index sizing.
package avl_mm_pkg;

   localparam logic [1:0] AVL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AVL_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AVL_RESP_DECERR = 2'b11;

   // Bits needed to name one of n hosts; never narrower than one bit.
   function automatic int unsigned host_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/avl_mm_idx_fifo.sv
// Small synchronous FIFO of host indices, used to route read data back in issue order.
module avl_mm_idx_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned W     = 1,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Status flags and head-of-queue view.
   always_comb begin
      full  = (cnt_q == CNT_W'(DEPTH));
      empty = (cnt_q == '0);
      head  = mem_q[rd_q];
      count = cnt_q;
   end

   // Next-state: pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/avl_mm_rr_mux.sv
// N-host to 1-agent Avalon-MM pipelined multiplexer with round-robin arbitration
// and in-order read-return routing. Request and response paths are combinational.
module avl_mm_rr_mux
   import avl_mm_pkg::*;
#(
   parameter  int unsigned N_HOSTS   = 2,
   parameter  int unsigned ADDR_W    = 32,
   parameter  int unsigned DATA_W    = 32,
   parameter  int unsigned MAX_OUTST = 4,
   localparam int unsigned BE_W      = DATA_W / 8,
   localparam int unsigned IDX_W     = host_idx_w(N_HOSTS),
   localparam int unsigned CNT_W     = $clog2(MAX_OUTST) + 1
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [N_HOSTS*ADDR_W-1:0] h_address,
   input  logic [N_HOSTS*DATA_W-1:0] h_writedata,
   input  logic [N_HOSTS*BE_W-1:0]   h_byteenable,
   input  logic [N_HOSTS-1:0]        h_read,
   input  logic [N_HOSTS-1:0]        h_write,
   output logic [N_HOSTS-1:0]        h_waitrequest,
   output logic [DATA_W-1:0]         h_readdata,
   output logic [N_HOSTS-1:0]        h_readdatavalid,
   output logic [1:0]                h_response,
   output logic [ADDR_W-1:0]         a_address,
   output logic [DATA_W-1:0]         a_writedata,
   output logic [BE_W-1:0]           a_byteenable,
   output logic                      a_read,
   output logic                      a_write,
   input  logic                      a_waitrequest,
   input  logic [DATA_W-1:0]         a_readdata,
   input  logic                      a_readdatavalid,
   input  logic [1:0]                a_response,
   output logic [CNT_W-1:0]          outst_cnt,
   output logic                      err_orphan
);

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
   logic               lock_q, lock_d;
   logic               err_orphan_q, err_orphan_d;

   logic [N_HOSTS-1:0] req_c, elig_c;
   logic [IDX_W-1:0]   grant_c, head_c;
   logic               g_read_c, g_write_c, accept_c, push_c, pop_c;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_cnt;

   // First eligible requester strictly after ptr, wrapping; returns ptr when none.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_HOSTS-1:0] r,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] sel;
      logic             found;
      int unsigned      j;
      sel   = ptr;
      found = 1'b0;
      for (int unsigned k = 1; k <= N_HOSTS; k++) begin
         j = (32'(ptr) + k) % N_HOSTS;
         if (!found && r[IDX_W'(j)]) begin
            sel   = IDX_W'(j);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // Arbitration: reads blocked by a full tracker are not eligible, so writes can still win.
   always_comb begin
      req_c     = h_read | h_write;
      elig_c    = req_c & ~(h_read & {N_HOSTS{fifo_full}});
      grant_c   = lock_q ? lock_idx_q : rr_pick(elig_c, rr_ptr_q);
      g_read_c  = h_read[grant_c] & ~fifo_full;
      g_write_c = h_write[grant_c] & ~h_read[grant_c];
      accept_c  = (g_read_c | g_write_c) & ~a_waitrequest;
      push_c    = g_read_c & ~a_waitrequest;
      pop_c     = a_readdatavalid & ~fifo_empty;
   end

   // Agent-side request mux and host-side stall/return routing.
   always_comb begin
      a_read       = g_read_c;
      a_write      = g_write_c;
      a_address    = h_address[32'(grant_c) * ADDR_W +: ADDR_W];
      a_writedata  = h_writedata[32'(grant_c) * DATA_W +: DATA_W];
      a_byteenable = h_byteenable[32'(grant_c) * BE_W +: BE_W];
      h_readdata   = a_readdata;
      h_response   = a_response;
      for (int i = 0; i < int'(N_HOSTS); i++) begin
         h_waitrequest[i]   = ~(accept_c && (grant_c == IDX_W'(i)));
         h_readdatavalid[i] = pop_c && (head_c == IDX_W'(i));
      end
      outst_cnt  = fifo_cnt;
      err_orphan = err_orphan_q;
   end

   // Next-state for pointer, grant lock and sticky orphan flag.
   always_comb begin
      lock_d       = (g_read_c | g_write_c) & a_waitrequest;
      lock_idx_d   = grant_c;
      rr_ptr_d     = accept_c ? grant_c : rr_ptr_q;
      err_orphan_d = err_orphan_q | (a_readdatavalid & fifo_empty);
   end

   // State registers.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rr_ptr_q     <= IDX_W'(N_HOSTS - 1);
         lock_idx_q   <= '0;
         lock_q       <= 1'b0;
         err_orphan_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_idx_q   <= lock_idx_d;
         lock_q       <= lock_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   // In-order record of which host owns each outstanding read.
   avl_mm_idx_fifo #(
      .DEPTH (MAX_OUTST),
      .W     (IDX_W)
   ) u_idx_fifo (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .push      (push_c),
      .push_data (grant_c),
      .pop       (pop_c),
      .head      (head_c),
      .count     (fifo_cnt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_avl_mm_rr_mux.sv
// Scoreboard bench for avl_mm_rr_mux: bench-side host and agent models, expected
// read returns queued at host acceptance and checked by a negedge monitor.
module tb_avl_mm_rr_mux;
   import avl_mm_pkg::*;

   localparam int unsigned N    = 2;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned BW   = DW / 8;
   localparam int unsigned MAXO = 4;
   localparam int unsigned CW   = $clog2(MAXO) + 1;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n;
   logic [N*AW-1:0]   h_address;
   logic [N*DW-1:0]   h_writedata;
   logic [N*BW-1:0]   h_byteenable;
   logic [N-1:0]      h_read, h_write, h_waitrequest, h_readdatavalid;
   logic [DW-1:0]     h_readdata;
   logic [1:0]        h_response;
   logic [AW-1:0]     a_address;
   logic [DW-1:0]     a_writedata;
   logic [BW-1:0]     a_byteenable;
   logic              a_read, a_write, a_waitrequest, a_readdatavalid;
   logic [DW-1:0]     a_readdata;
   logic [1:0]        a_response;
   logic [CW-1:0]     outst_cnt;
   logic              err_orphan;

   always #5 clk_clk = ~clk_clk;

   avl_mm_rr_mux #(.N_HOSTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .h_address(h_address), .h_writedata(h_writedata), .h_byteenable(h_byteenable),
      .h_read(h_read), .h_write(h_write), .h_waitrequest(h_waitrequest),
      .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid), .h_response(h_response),
      .a_address(a_address), .a_writedata(a_writedata), .a_byteenable(a_byteenable),
      .a_read(a_read), .a_write(a_write), .a_waitrequest(a_waitrequest),
      .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid), .a_response(a_response),
      .outst_cnt(outst_cnt), .err_orphan(err_orphan));

   typedef struct {bit rd; logic [AW-1:0] addr; logic [DW-1:0] wd; logic [BW-1:0] be;} cmd_t;
   typedef struct {logic [N-1:0] hv; logic [DW-1:0] data; logic [1:0] resp;} exp_t;
   typedef struct {logic [DW-1:0] data; logic [1:0] resp; int due;} rsp_t;

   cmd_t cmdq[N][$];
   cmd_t cur[N];
   bit   host_act[N];
   bit   acc_flag[N];
   exp_t sb[$];
   exp_t rdv_log[$];
   rsp_t rspq[$];
   int   acc_log[$];
   int   cyc;
   bit   force_wait, rand_wait, hold_rdv, inject_orphan;
   int   lat_lo = 2, lat_hi = 2;
   int   n_tests, n_fail;

   // Agent memory contents and response code, both derived from the address.
   function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
      return (a[2] ? 32'h5A5A_0000 : 32'hA5A5_0000) | {16'h0, a[18:3]};
   endfunction

   function automatic logic [1:0] mem_resp(input logic [AW-1:0] a);
      case (a[31:28])
         4'hE:    return AVL_RESP_SLVERR;
         4'hF:    return AVL_RESP_DECERR;
         default: return AVL_RESP_OKAY;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Advance one cycle and drive host and agent inputs #1 after the edge.
   task automatic step();
      @(posedge clk_clk);
      #1;
      cyc++;
      for (int i = 0; i < int'(N); i++) begin
         if (acc_flag[i]) begin
            host_act[i] = 1'b0;
            acc_flag[i] = 1'b0;
         end
         if (!host_act[i] && cmdq[i].size() > 0) begin
            cur[i]      = cmdq[i].pop_front();
            host_act[i] = 1'b1;
         end
         h_read[i]                  = host_act[i] && cur[i].rd;
         h_write[i]                 = host_act[i] && !cur[i].rd;
         h_address[i*AW +: AW]      = cur[i].addr;
         h_writedata[i*DW +: DW]    = cur[i].wd;
         h_byteenable[i*BW +: BW]   = cur[i].be;
      end
      a_waitrequest = force_wait || (rand_wait && $urandom_range(0, 2) == 0);
      if (inject_orphan) begin
         a_readdatavalid = 1'b1;
         a_readdata      = 32'hDEAD_BEEF;
         a_response      = AVL_RESP_OKAY;
      end else if (!hold_rdv && rspq.size() > 0 && rspq[0].due <= cyc) begin
         rsp_t r;
         r = rspq.pop_front();
         a_readdatavalid = 1'b1;
         a_readdata      = r.data;
         a_response      = r.resp;
      end else begin
         a_readdatavalid = 1'b0;
         a_readdata      = $urandom;
         a_response      = 2'b01;
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   function automatic bit idle();
      bit r;
      r = (sb.size() == 0) && (rspq.size() == 0);
      for (int i = 0; i < int'(N); i++) begin
         if (host_act[i] || cmdq[i].size() > 0) r = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (!idle() && k < budget) begin
         step();
         k++;
      end
      if (!idle()) chk("idle_timeout", 64'(0), 64'(1));
   endtask

   function automatic cmd_t mk(input bit rd, input logic [AW-1:0] a);
      cmd_t c;
      c.rd = rd; c.addr = a; c.wd = $urandom; c.be = BW'($urandom);
      return c;
   endfunction

   // Monitor: checks returns against the scoreboard, acceptances against the host model.
   task automatic mon();
      int nacc;
      chk("outst_cnt", 64'(outst_cnt), 64'(sb.size()));
      if (outst_cnt == CW'(MAXO)) chk("full_blocks_read", 64'(a_read), 64'(0));
      if (a_readdatavalid) begin
         rdv_log.push_back('{hv: h_readdatavalid, data: h_readdata, resp: h_response});
         if (sb.size() == 0) begin
            chk("orphan_dropped", 64'(h_readdatavalid), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdv_host", 64'(h_readdatavalid), 64'(e.hv));
            chk("rdv_data", 64'(h_readdata), 64'(e.data));
            chk("rdv_resp", 64'(h_response), 64'(e.resp));
         end
      end else if (h_readdatavalid != '0) begin
         chk("rdv_spurious", 64'(h_readdatavalid), 64'(0));
      end
      nacc = 0;
      for (int i = 0; i < int'(N); i++) begin
         if (host_act[i] && !acc_flag[i]) begin
            if (!h_waitrequest[i]) begin
               nacc++;
               chk("acc_addr", 64'(a_address), 64'(cur[i].addr));
               if (cur[i].rd) begin
                  logic [N-1:0] hv;
                  hv = '0;
                  hv[i] = 1'b1;
                  chk("acc_rd", 64'({a_read, a_write}), 64'(2'b10));
                  sb.push_back('{hv: hv, data: mem_data(cur[i].addr), resp: mem_resp(cur[i].addr)});
               end else begin
                  chk("acc_wr", 64'({a_read, a_write}), 64'(2'b01));
                  chk("acc_wdata", 64'(a_writedata), 64'(cur[i].wd));
                  chk("acc_be", 64'(a_byteenable), 64'(cur[i].be));
               end
               acc_log.push_back(i);
               acc_flag[i] = 1'b1;
            end
         end else if (!host_act[i]) begin
            chk("idle_waitreq", 64'(h_waitrequest[i]), 64'(1));
         end
      end
      if (nacc > 0) chk("one_grant", 64'(nacc), 64'(1));
      if (a_read && !a_waitrequest) begin
         rspq.push_back('{data: mem_data(a_address), resp: mem_resp(a_address),
                          due: cyc + int'($urandom_range(lat_lo, lat_hi))});
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_clk);
         if (reset_reset_n) mon();
      end
   end

   initial begin
      reset_reset_n = 1'b0;
      h_read = '0; h_write = '0; h_address = '0; h_writedata = '0; h_byteenable = '0;
      a_waitrequest = 1'b0; a_readdatavalid = 1'b0; a_readdata = '0; a_response = '0;
      repeat (2) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      step();
      chk("rst_waitreq", 64'(h_waitrequest), 64'(2'b11));
      chk("rst_agent_req", 64'({a_read, a_write}), 64'(0));
      chk("rst_outst", 64'(outst_cnt), 64'(0));
      chk("rst_orphan", 64'(err_orphan), 64'(0));

      // Simultaneous reads: host 0 first, then host 1.
      acc_log.delete(); rdv_log.delete();
      cmdq[0].push_back(mk(1'b1, 32'h0000_0000));
      cmdq[1].push_back(mk(1'b1, 32'h0000_000C));
      wait_idle(50);
      chk("t1_order0", 64'(acc_log[0]), 64'(0));
      chk("t1_order1", 64'(acc_log[1]), 64'(1));
      chk("t1_rdv0", {30'h0, rdv_log[0].hv, rdv_log[0].data}, {30'h0, 2'b01, 32'hA5A5_0000});
      chk("t1_rdv1", {30'h0, rdv_log[1].hv, rdv_log[1].data}, {30'h0, 2'b10, 32'h5A5A_0001});

      // Lock: stalled host-1 request holds the agent until accepted.
      acc_log.delete();
      force_wait = 1'b1;
      cmdq[1].push_back(mk(1'b1, 32'h0000_0100));
      step();
      chk("t2_addr_a", 64'(a_address), 64'(32'h100));
      cmdq[0].push_back(mk(1'b1, 32'h0000_0200));
      for (int k = 0; k < 2; k++) begin
         step();
         chk("t2_addr_held", 64'(a_address), 64'(32'h100));
         chk("t2_all_stall", 64'(h_waitrequest), 64'(2'b11));
      end
      force_wait = 1'b0;
      wait_idle(50);
      chk("t2_first", 64'(acc_log[0]), 64'(1));
      chk("t2_second", 64'(acc_log[1]), 64'(0));

      // Read blocking at MAX_OUTST; a write still passes.
      acc_log.delete();
      hold_rdv = 1'b1;
      for (int k = 0; k < 5; k++) cmdq[0].push_back(mk(1'b1, 32'h10 + 32'(4 * k)));
      run(10);
      chk("t3_outst_full", 64'(outst_cnt), 64'(MAXO));
      chk("t3_fifth_stalled", 64'({h_read[0], h_waitrequest[0], a_read}), 64'(3'b110));
      cmdq[1].push_back(mk(1'b0, 32'h0000_0040));
      run(3);
      chk("t3_write_passes", 64'(acc_log[acc_log.size() - 1]), 64'(1));
      hold_rdv = 1'b0;
      wait_idle(60);
      chk("t3_accepts", 64'(acc_log.size()), 64'(6));

      // Orphan read data.
      inject_orphan = 1'b1;
      step();
      inject_orphan = 1'b0;
      step();
      chk("t4_orphan_set", 64'(err_orphan), 64'(1));
      run(5);
      chk("t4_orphan_sticky", 64'(err_orphan), 64'(1));

      // Error response routed to host 1.
      rdv_log.delete();
      cmdq[1].push_back(mk(1'b1, 32'hE000_0010));
      wait_idle(50);
      chk("t5_hv", 64'(rdv_log[0].hv), 64'(2'b10));
      chk("t5_resp", 64'(rdv_log[0].resp), 64'(2'b10));

      // Continuous writes from both hosts alternate.
      acc_log.delete();
      for (int k = 0; k < 4; k++) begin
         cmdq[0].push_back(mk(1'b0, 32'h1000 + 32'(k)));
         cmdq[1].push_back(mk(1'b0, 32'h2000 + 32'(k)));
      end
      wait_idle(50);
      for (int k = 0; k < 8; k++) chk("t6_alternate", 64'(acc_log[k]), 64'(k % 2));

      // Reset with three reads outstanding; host 0 last won, so host 0 first after reset proves rr_ptr reset.
      hold_rdv = 1'b1;
      for (int k = 0; k < 3; k++) cmdq[0].push_back(mk(1'b1, 32'h300 + 32'(4 * k)));
      run(8);
      chk("t7_outst3", 64'(outst_cnt), 64'(3));
      reset_reset_n = 1'b0;
      sb.delete(); rspq.delete();
      hold_rdv = 1'b0;
      run(2);
      chk("t7_rst_outst", 64'(outst_cnt), 64'(0));
      chk("t7_rst_orphan", 64'(err_orphan), 64'(0));
      reset_reset_n = 1'b1;
      step();
      acc_log.delete();
      cmdq[0].push_back(mk(1'b0, 32'h500));
      cmdq[1].push_back(mk(1'b0, 32'h600));
      wait_idle(50);
      chk("t7_first_after_rst", 64'(acc_log[0]), 64'(0));

      // Randomized traffic with random stalls, latency and withheld returns.
      rand_wait = 1'b1; lat_lo = 1; lat_hi = 4;
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < int'(N); i++) begin
            if (cmdq[i].size() < 2 && $urandom_range(0, 2) == 0) begin
               logic [AW-1:0] a;
               a = {$urandom} & 32'h0FFF_FFFC;
               case ($urandom_range(0, 3))
                  0:       a[31:28] = 4'hE;
                  1:       a[31:28] = 4'hF;
                  default: a[31:28] = 4'h0;
               endcase
               cmdq[i].push_back(mk(1'($urandom_range(0, 1)), a));
            end
         end
         hold_rdv = ($urandom_range(0, 9) < 3);
         step();
      end
      hold_rdv = 1'b0;
      wait_idle(2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/avl_mm_rr_mux.md
Name: avl_mm_rr_mux

Overview:
Parametrised N-host to 1-agent Avalon-MM pipelined multiplexer. It lets the SCR1 imem/dmem ports, and later accelerator hosts, share one pipelined memory agent such as the SDRAM controller or on-chip RAM.
- Round-robin arbitration across hosts.
- Holds a stalled request stable until the agent accepts it.
- Tracks outstanding reads in order, so each readdatavalid and response returns to the host that issued the read.
- Zero added latency on the request and response paths.

Parameters:
N_HOSTS, 2, number of host ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MAX_OUTST, 4, maximum outstanding reads, power of 2 (2..16)

Ports:
clk_clk  in  1  clock
reset_reset_n  in  1  asynchronous active-low reset
h_address  in  N_HOSTS*ADDR_W  host addresses, host i at slice i
h_writedata  in  N_HOSTS*DATA_W  host write data
h_byteenable  in  N_HOSTS*DATA_W/8  host byte enables
h_read  in  N_HOSTS  host read requests
h_write  in  N_HOSTS  host write requests
h_waitrequest  out  N_HOSTS  per-host stall
h_readdata  out  DATA_W  shared read data, qualified by h_readdatavalid
h_readdatavalid  out  N_HOSTS  per-host read-data valid
h_response  out  2  shared response code, qualified by h_readdatavalid
a_address  out  ADDR_W  agent address
a_writedata  out  DATA_W  agent write data
a_byteenable  out  DATA_W/8  agent byte enables
a_read  out  1  agent read
a_write  out  1  agent write
a_waitrequest  in  1  agent stall
a_readdata  in  DATA_W  agent read data
a_readdatavalid  in  1  agent read-data valid
a_response  in  2  agent response
outst_cnt  out  $clog2(MAX_OUTST)+1  current number of outstanding reads
err_orphan  out  1  sticky: readdatavalid seen with no outstanding read

Behaviour:
- Host i is requesting when h_read[i] or h_write[i] is high. A host asserting both at once is illegal; the read is taken.
- Arbitration:
  - rr_ptr register, reset value N_HOSTS-1, so host 0 has priority after reset.
  - When unlocked, grant the first requester at or after rr_ptr+1 (modulo N_HOSTS).
- Lock:
  - lock=1 whenever a granted request is presented and a_waitrequest=1; the grant is then frozen until acceptance.
  - Acceptance = (a_read|a_write) && !a_waitrequest. On acceptance: rr_ptr <= granted index, lock <= 0.
- Agent outputs:
  - Combinational mux of the granted host's signals.
  - a_read/a_write are 0 when no host is requesting.
  - a_read is forced 0 when the FIFO is full (see read blocking).
- h_waitrequest[i] = !(granted_i && accept_possible). Non-granted requesting hosts see waitrequest=1; idle hosts see 1.
- Read tracking FIFO:
  - Depth MAX_OUTST, entry width $clog2(N_HOSTS).
  - Push granted index on read acceptance; pop on a_readdatavalid.
- Read blocking:
  - When count==MAX_OUTST, a granted read is not presented (a_read=0) and the host stalls.
  - This holds even if a pop occurs in the same cycle (no bypass).
  - A write may win arbitration while reads are blocked.
- Return path:
  - h_readdatavalid[head]=a_readdatavalid; all other bits are 0.
  - h_readdata=a_readdata and h_response=a_response, combinational.
- Orphan handling: a_readdatavalid while the FIFO is empty is dropped (all h_readdatavalid=0) and sets err_orphan. err_orphan clears only on reset.
- Simultaneous push and pop (count<MAX): count unchanged, both pointers advance, and pointers wrap modulo MAX_OUTST.
- Writes are posted and are not tracked.
- Reset values: rr_ptr=N_HOSTS-1, lock=0, FIFO empty, outst_cnt=0, err_orphan=0.
  - Combinational outputs follow from those values: a_read=a_write=0 if no request; h_waitrequest all 1 while idle.
- Reset mid-operation flushes outstanding reads. The agent must be reset from the same reset domain.

Decomposition:
- Package avl_mm_pkg holds:
  - response codes: AVL_RESP_OKAY=2'b00, AVL_RESP_SLVERR=2'b10, AVL_RESP_DECERR=2'b11
  - the host-index width function.
- Sub-module avl_mm_idx_fifo: synchronous FIFO with count output, async active-low reset, parametrised by depth and entry width.
- Round-robin pick is a function inside the top module.

Test Plan:
- Host 0 and host 1 read simultaneously, agent has 0 waitrequest and 2-cycle read latency -> host 0 is granted first, host 1 next cycle; readdatavalid lands on h_readdatavalid[0] then [1], with matching data 0xA5A5_0000 and 0x5A5A_0001.
- Agent waitrequest held high 3 cycles while host 1 reads address 0x100 and host 0 starts requesting -> a_address stays 0x100 and lock holds the grant; host 0 is granted only after acceptance.
- MAX_OUTST=4 with agent readdatavalid withheld, host 0 issues 5 reads -> 4 accepted, outst_cnt=4, 5th stalled with a_read=0; a write from host 1 is still accepted; after one readdatavalid the 5th read proceeds.
- a_readdatavalid pulse with outst_cnt=0 -> no h_readdatavalid, err_orphan=1 and it stays 1.
- a_response=2'b10 on a read issued by host 1 -> h_response=2'b10 with h_readdatavalid=2'b10.
- reset_reset_n pulled low with 3 reads outstanding -> outst_cnt=0, rr_ptr resets, next grant goes to host 0.
